// File: rtl/snax_clint_pkg.sv
// Shared constants and types for the CLINT register block: address map offsets,
// response FSM state encoding, the 64-bit timer type and a byte-strobe merge helper.
package snax_clint_pkg;

  localparam logic [15:0] MsipBase     = 16'h0000;
  localparam logic [15:0] MtimecmpBase = 16'h4000;
  localparam logic [15:0] MtimeLo      = 16'hBFF8;
  localparam logic [15:0] MtimeHi      = 16'hBFFC;

  typedef enum logic {Idle, Resp} clint_state_e;

  typedef logic [63:0] mtime_t;

  // Replace only the bytes of old_word whose strobe bit is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/snax_clint_timer.sv
// Free-running 64-bit mtime counter with per-word software override.
// Optional tick prescaler enabled by the SNAX_CLINT_PRESCALER_EN macro.
module snax_clint_timer
  import snax_clint_pkg::*;
#(
  parameter int unsigned PrescaleDiv = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  strb_i,
  output mtime_t      mtime_o
);

  mtime_t mtime_q;
  logic   tick;

`ifdef SNAX_CLINT_PRESCALER_EN
  localparam int unsigned CntW = $clog2(PrescaleDiv);

  logic [CntW-1:0] pre_cnt_q;

  assign tick = (pre_cnt_q == CntW'(PrescaleDiv - 1));

  // A software mtime write restarts the tick period so the new value lasts a full period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt_q <= '0;
    end else if (wr_lo_i || wr_hi_i || tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + 1'b1;
    end
  end
`else
  localparam int unsigned unused_prescale_div = PrescaleDiv;

  assign tick = 1'b1;
`endif

  // A word write wins over the increment; the other word is left untouched, no carry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q <= '0;
    end else if (wr_lo_i) begin
      mtime_q[31:0] <= apply_strb(mtime_q[31:0], wdata_i, strb_i);
    end else if (wr_hi_i) begin
      mtime_q[63:32] <= apply_strb(mtime_q[63:32], wdata_i, strb_i);
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/snax_clint_regs.sv
// Core-local interruptor: msip / mtimecmp / mtime registers behind a 32-bit valid/ready port.
// Build option: SNAX_CLINT_PRESCALER_EN slows mtime to one tick per PrescaleDiv cycles.
module snax_clint_regs
  import snax_clint_pkg::*;
#(
  parameter int unsigned NrCores     = 8,
  parameter int unsigned AddrWidth   = 48,
  parameter int unsigned PrescaleDiv = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_strb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NrCores-1:0]   msip_o,
  output logic [NrCores-1:0]   mtip_o
);

  localparam logic [5:0] NrCoresW = 6'(NrCores);

  clint_state_e       state_q;
  logic               ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_error_q;
  logic [NrCores-1:0] msip_q;
  logic [NrCores-1:0] mtip_q;
  mtime_t             cmp_q [NrCores];
  mtime_t             mtime;

  logic [15:0] offset;
  logic [4:0]  msip_idx;
  logic [4:0]  cmp_idx;
  logic        cmp_hi;
  logic        sel_msip;
  logic        sel_cmp;
  logic        sel_mtime_lo;
  logic        sel_mtime_hi;
  logic        mapped;
  logic        accept;
  logic        do_write;
  logic [31:0] rdata_d;

  // Address decode: only the low 16 bits select a register, word granularity.
  assign offset       = req_addr_i[15:0];
  assign msip_idx     = offset[6:2];
  assign cmp_idx      = offset[7:3];
  assign cmp_hi       = offset[2];
  assign sel_msip     = (offset[15:7] == MsipBase[15:7]) && ({1'b0, msip_idx} < NrCoresW);
  assign sel_cmp      = (offset[15:8] == MtimecmpBase[15:8]) && ({1'b0, cmp_idx} < NrCoresW);
  assign sel_mtime_lo = (offset[15:2] == MtimeLo[15:2]);
  assign sel_mtime_hi = (offset[15:2] == MtimeHi[15:2]);
  assign mapped       = sel_msip || sel_cmp || sel_mtime_lo || sel_mtime_hi;

  assign accept   = req_valid_i && (state_q == Idle);
  assign do_write = accept && req_write_i;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^offset[1:0];

  if (AddrWidth > 16) begin : g_addr_upper
    logic unused_addr_upper;
    assign unused_addr_upper = ^req_addr_i[AddrWidth-1:16];
  end

  // Read data reflects the register state present in the handshake cycle.
  always_comb begin
    rdata_d = '0;
    if (!req_write_i) begin
      for (int i = 0; i < NrCores; i++) begin
        if (sel_msip && (msip_idx == 5'(i))) begin
          rdata_d = {31'd0, msip_q[i]};
        end
        if (sel_cmp && (cmp_idx == 5'(i))) begin
          rdata_d = cmp_hi ? cmp_q[i][63:32] : cmp_q[i][31:0];
        end
      end
      if (sel_mtime_lo) begin
        rdata_d = mtime[31:0];
      end
      if (sel_mtime_hi) begin
        rdata_d = mtime[63:32];
      end
    end
  end

  // Request / response FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (req_valid_i) begin
            state_q     <= Resp;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= mapped ? rdata_d : 32'd0;
            rsp_error_q <= !mapped;
          end
        end
        Resp: begin
          if (rsp_ready_i) begin
            state_q     <= Idle;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= Idle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Software interrupt pending bits and timer compare values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msip_q <= '0;
      for (int i = 0; i < NrCores; i++) begin
        cmp_q[i] <= '1;
      end
    end else if (do_write) begin
      for (int i = 0; i < NrCores; i++) begin
        if (sel_msip && (msip_idx == 5'(i)) && req_strb_i[0]) begin
          msip_q[i] <= req_wdata_i[0];
        end
        if (sel_cmp && (cmp_idx == 5'(i))) begin
          if (cmp_hi) begin
            cmp_q[i][63:32] <= apply_strb(cmp_q[i][63:32], req_wdata_i, req_strb_i);
          end else begin
            cmp_q[i][31:0] <= apply_strb(cmp_q[i][31:0], req_wdata_i, req_strb_i);
          end
        end
      end
    end
  end

  snax_clint_timer #(
    .PrescaleDiv(PrescaleDiv)
  ) i_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wr_lo_i(do_write && sel_mtime_lo),
    .wr_hi_i(do_write && sel_mtime_hi),
    .wdata_i(req_wdata_i),
    .strb_i (req_strb_i),
    .mtime_o(mtime)
  );

  // Compare stage: one register between the 64-bit compare and the interrupt lines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtip_q <= '0;
    end else begin
      for (int i = 0; i < NrCores; i++) begin
        mtip_q[i] <= (mtime >= cmp_q[i]);
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign msip_o      = msip_q;
  assign mtip_o      = mtip_q;

endmodule
